// File: rtl/decoder_pkg.sv
// Shared constants and helpers for the decoder_scan block: state encoding,
// mode values and a width-generic one-hot decode function.
package decoder_pkg;

  localparam int unsigned MAX_SEL_W = 5;
  localparam int unsigned MAX_OUT_N = 32;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_DIRECT = 2'd1;
  localparam logic [1:0] ST_SCAN   = 2'd2;

  localparam logic MODE_DIRECT = 1'b0;
  localparam logic MODE_SCAN   = 1'b1;

  // Decode at the widest legal size; callers truncate to their OUT_N.
  function automatic logic [MAX_OUT_N-1:0] onehot(input logic [MAX_SEL_W-1:0] s);
    logic [MAX_OUT_N-1:0] v;
    v    = '0;
    v[s] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/decoder_scan_tick_gen.sv
// Scan prescaler: counts 0..PRESCALE-1 while enabled and flags the wrap cycle.
module tick_gen #(
  parameter int unsigned PRESCALE = 100000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic wrap_c
);

  localparam int unsigned CNT_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(PRESCALE - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  assign wrap_c = en && (cnt_q == CNT_MAX);

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = wrap_c ? '0 : CNT_W'(cnt_q + 1'b1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/decoder_scan.sv
// Registered binary-to-one-hot decoder with prescaled auto-scan.
// Define DECODER_SCAN_ACTIVE_LOW_EN to invert out (idle/reset all-ones).
module decoder_scan
  import decoder_pkg::*;
#(
  parameter int unsigned SEL_W    = 3,
  parameter int unsigned PRESCALE = 100000
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    en,
  input  logic                    mode,
  input  logic [SEL_W-1:0]        sel,
  input  logic [SEL_W-1:0]        last,
  output logic [(2**SEL_W)-1:0]   out,
  output logic [SEL_W-1:0]        idx,
  output logic                    tick
);

  localparam int unsigned OUT_N = 2 ** SEL_W;

`ifdef DECODER_SCAN_ACTIVE_LOW_EN
  localparam logic [OUT_N-1:0] OUT_IDLE = '1;
`else
  localparam logic [OUT_N-1:0] OUT_IDLE = '0;
`endif

  logic [1:0]       state_q, state_d;
  logic [SEL_W-1:0] idx_q, idx_d;
  logic [OUT_N-1:0] out_q, out_d;
  logic             tick_q, tick_d;
  logic             scan_run_c;
  logic             wrap_c;

  // Prescaler only runs once SCAN has been entered and stays selected.
  assign scan_run_c = en && (mode == MODE_SCAN) && (state_q == ST_SCAN);

  tick_gen #(
    .PRESCALE (PRESCALE)
  ) u_tick_gen (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (!scan_run_c),
    .en     (scan_run_c),
    .wrap_c (wrap_c)
  );

  always_comb begin
    state_d = ST_IDLE;
    idx_d   = '0;
    out_d   = OUT_IDLE;
    tick_d  = 1'b0;
    if (en) begin
      if (mode == MODE_DIRECT) begin
        state_d = ST_DIRECT;
        idx_d   = sel;
      end else begin
        state_d = ST_SCAN;
        idx_d   = '0;
        if (state_q == ST_SCAN) begin
          idx_d = idx_q;
          if (wrap_c) begin
            tick_d = 1'b1;
            idx_d  = (idx_q >= last) ? '0 : SEL_W'(idx_q + 1'b1);
          end
        end
      end
      out_d = OUT_N'(onehot(MAX_SEL_W'(idx_d))) ^ OUT_IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      out_q   <= OUT_IDLE;
      tick_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      out_q   <= out_d;
      tick_q  <= tick_d;
    end
  end

  assign out  = out_q;
  assign idx  = idx_q;
  assign tick = tick_q;

endmodule

// File: tb/tb_decoder_scan.sv
// Randomized bench for decoder_scan (SEL_W=3, PRESCALE=4) against a dwell-count model.
module tb_decoder_scan;

  localparam int unsigned SEL_W    = 3;
  localparam int unsigned PRESCALE = 4;
  localparam int unsigned OUT_N    = 8;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             en = 1'b0;
  logic             mode = 1'b0;
  logic [SEL_W-1:0] sel = '0;
  logic [SEL_W-1:0] last = '0;
  logic [OUT_N-1:0] out;
  logic [SEL_W-1:0] idx;
  logic             tick;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  // Reference state: index shown, how many cycles it has been shown, scanning flag.
  int unsigned m_idx = 0;
  int unsigned m_dwell = 0;
  bit          m_scanning = 1'b0;
  bit          m_active = 1'b0;
  bit          m_tick = 1'b0;

  decoder_scan #(
    .SEL_W    (SEL_W),
    .PRESCALE (PRESCALE)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (en),
    .mode  (mode),
    .sel   (sel),
    .last  (last),
    .out   (out),
    .idx   (idx),
    .tick  (tick)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int unsigned got, input int unsigned exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int unsigned exp_out();
    int unsigned v;
    v = m_active ? (32'd1 << m_idx) : 32'd0;
`ifdef DECODER_SCAN_ACTIVE_LOW_EN
    v = ~v & 32'hFF;
`endif
    return v;
  endfunction

  // Apply the rules for one rising edge using the inputs that were stable at it.
  task automatic model_edge();
    m_tick = 1'b0;
    if (!rst_n || !en) begin
      m_active = 1'b0; m_scanning = 1'b0; m_idx = 0; m_dwell = 0;
    end else if (!mode) begin
      m_active = 1'b1; m_scanning = 1'b0; m_idx = int'(sel); m_dwell = 0;
    end else if (!m_scanning) begin
      m_active = 1'b1; m_scanning = 1'b1; m_idx = 0; m_dwell = 1;
    end else if (m_dwell == PRESCALE) begin
      m_idx = (m_idx >= int'(last)) ? 0 : m_idx + 1;
      m_dwell = 1;
      m_tick = 1'b1;
    end else begin
      m_dwell++;
    end
  endtask

  task automatic step(input string tag);
    @(posedge clk);
    model_edge();
    #1;
    check({tag, ".out"}, int'(out), exp_out());
    check({tag, ".idx"}, int'(idx), m_idx);
    check({tag, ".tick"}, int'(tick), int'(m_tick));
  endtask

  initial begin
    int unsigned guard;

    // Reset held two edges while the scan inputs are asserted.
    rst_n = 1'b0; en = 1'b1; mode = 1'b1; last = 3'd7;
    step("reset0");
    step("reset1");
`ifndef DECODER_SCAN_ACTIVE_LOW_EN
    check("reset_out_lit", int'(out), 32'h00);
`else
    check("reset_out_lit", int'(out), 32'hFF);
`endif
    rst_n = 1'b1;

    // Direct sweep.
    mode = 1'b0;
    for (int s = 0; s < 8; s++) begin
      sel = 3'(s);
      step("direct");
    end
`ifndef DECODER_SCAN_ACTIVE_LOW_EN
    check("direct_sel7_lit", int'(out), 32'h80);
`endif
    sel = 3'd2;
    step("direct2");
`ifdef DECODER_SCAN_ACTIVE_LOW_EN
    check("direct_sel2_lo_lit", int'(out), 32'hFB);
`endif

    // Full scan over two periods.
    mode = 1'b1; last = 3'd7;
    for (int c = 0; c < 66; c++) step("scan_full");

    // Short scan then lower last while idx=2.
    mode = 1'b0; step("to_direct");
    mode = 1'b1; last = 3'd2;
    guard = 0;
    while (!(m_idx == 2 && m_dwell == 1) && guard < 64) begin
      step("scan_short");
      guard++;
    end
    check("reach_idx2", m_idx, 2);
    last = 3'd0;
    for (int c = 0; c < 20; c++) step("scan_last0");

    // Interrupt at idx=5, re-enable, then switch to direct with sel=6.
    last = 3'd7; mode = 1'b0; step("restart");
    mode = 1'b1;
    guard = 0;
    while (m_idx != 5 && guard < 64) begin
      step("scan_to5");
      guard++;
    end
    check("reach_idx5", int'(idx), 5);
    en = 1'b0; step("en_drop");
    en = 1'b1;
    for (int c = 0; c < 6; c++) step("reenter");
    sel = 3'd6; mode = 1'b0; step("mode_switch");
`ifndef DECODER_SCAN_ACTIVE_LOW_EN
    check("mode_switch_lit", int'(out), 32'h40);
`endif

    // Mid-scan reset pulse.
    mode = 1'b1;
    for (int c = 0; c < 7; c++) step("pre_rst");
    rst_n = 1'b0; step("mid_rst");
`ifdef DECODER_SCAN_ACTIVE_LOW_EN
    check("mid_rst_lo_lit", int'(out), 32'hFF);
`endif
    rst_n = 1'b1;

    // Randomized phase.
    for (int c = 0; c < 800; c++) begin
      if ($urandom_range(0, 15) == 0) en = ~en;
      if ($urandom_range(0, 19) == 0) mode = ~mode;
      if ($urandom_range(0, 11) == 0) last = 3'($urandom_range(0, 7));
      sel   = 3'($urandom_range(0, 7));
      rst_n = ($urandom_range(0, 99) != 0);
      step("rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
